// File: rtl/aes64_ctrl_pkg.sv
// Shared types and constants for the aes64 block sequencer.
`ifndef AES64_BYTE
`define AES64_BYTE(i) (8*(i)) +: 8
`endif

package aes64_ctrl_pkg;

  localparam int unsigned BLK_W     = 128;
  localparam int unsigned HALF_W    = 64;
  localparam int unsigned NUM_BYTES = 16;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } ctrl_state_e;

  // Legal round counts (AES-128/192/256)
  localparam int unsigned NR_AES128 = 10;
  localparam int unsigned NR_AES192 = 12;
  localparam int unsigned NR_AES256 = 14;

  // Op one-hot vector order {enc, dec, imix, ks1, ks2}, shared with aes64
  localparam int unsigned OP_W    = 5;
  localparam int unsigned OP_ENC  = 4;
  localparam int unsigned OP_DEC  = 3;
  localparam int unsigned OP_IMIX = 2;
  localparam int unsigned OP_KS1  = 1;
  localparam int unsigned OP_KS2  = 0;

  typedef logic [OP_W-1:0] aes64_op_t;

  // True for a supported number of rounds
  function automatic logic nr_is_legal(input int unsigned nr);
    return (nr == NR_AES128) || (nr == NR_AES192) || (nr == NR_AES256);
  endfunction

endpackage

// File: rtl/aes64_rk_mux.sv
// Round-key index selection and AddRoundKey for the block sequencer.
module aes64_rk_mux
  import aes64_ctrl_pkg::*;
#(
  parameter int unsigned NR  = 10,
  parameter int unsigned RKW = 4
) (
  input  logic             idle,
  input  logic             dec,
  input  logic [RKW-1:0]   rnd,
  input  logic [BLK_W-1:0] src,
  input  logic [BLK_W-1:0] rk,
  output logic [RKW-1:0]   rk_idx,
  output logic [BLK_W-1:0] ark
);

  localparam logic [RKW-1:0] NR_IDX = RKW'(NR);

  // Whitening key while idle, then one key per round (reversed for decrypt)
  always_comb begin
    rk_idx = '0;
    if (idle) begin
      rk_idx = dec ? NR_IDX : '0;
    end else begin
      rk_idx = dec ? (NR_IDX - rnd) : rnd;
    end
  end

  // Bytewise AddRoundKey
  always_comb begin
    ark = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      ark[`AES64_BYTE(b)] = src[`AES64_BYTE(b)] ^ rk[`AES64_BYTE(b)];
    end
  end

endmodule

// File: rtl/aes64_block_ctrl.sv
// Runs a full AES block encrypt/decrypt as lo/hi half-round micro-ops on a
// shared aes64 datapath, applying AddRoundKey locally.
module aes64_block_ctrl
  import aes64_ctrl_pkg::*;
#(
  parameter int unsigned NR  = 10,
  parameter int unsigned RKW = 4
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_dec,
  input  logic [BLK_W-1:0]  in_blk,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BLK_W-1:0]  out_blk,
  output logic [RKW-1:0]    rk_idx,
  input  logic [BLK_W-1:0]  rk,
  output logic              dp_valid,
  output logic              dp_hi,
  output logic              dp_mix,
  output logic              dp_op_enc,
  output logic              dp_op_dec,
  output logic [HALF_W-1:0] dp_rs1,
  output logic [HALF_W-1:0] dp_rs2,
  input  logic [HALF_W-1:0] dp_rd,
  input  logic              dp_ready
);

  localparam logic [RKW-1:0] NR_IDX    = RKW'(NR);
  localparam logic [RKW-1:0] RND_FIRST = RKW'(1);

  if (!nr_is_legal(NR)) begin : g_bad_nr
    $error("aes64_block_ctrl: NR must be 10, 12 or 14");
  end
  if (NR >= (2 ** RKW)) begin : g_bad_rkw
    $error("aes64_block_ctrl: RKW too narrow for NR");
  end

  ctrl_state_e       fsm_q, fsm_d;
  logic              mode_q;
  logic [RKW-1:0]    rnd_q;
  logic [BLK_W-1:0]  state_q;
  logic [HALF_W-1:0] lo_hold_q;

  logic              idle_c;
  logic              last_rnd_c;
  logic              dec_sel_c;
  logic [BLK_W-1:0]  ark_src_c;
  logic [BLK_W-1:0]  ark_c;

  assign idle_c     = (fsm_q == ST_IDLE);
  assign last_rnd_c = (rnd_q == NR_IDX);
  assign dec_sel_c  = idle_c ? in_dec : mode_q;
  assign ark_src_c  = (fsm_q == ST_HI) ? {dp_rd, lo_hold_q} : in_blk;

  aes64_rk_mux #(
    .NR  (NR),
    .RKW (RKW)
  ) u_rk_mux (
    .idle   (idle_c),
    .dec    (dec_sel_c),
    .rnd    (rnd_q),
    .src    (ark_src_c),
    .rk     (rk),
    .rk_idx (rk_idx),
    .ark    (ark_c)
  );

  // FSM state register
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      fsm_q <= ST_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // Next-state logic
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE: if (in_valid)  fsm_d = ST_LO;
      ST_LO:   if (dp_ready)  fsm_d = ST_HI;
      ST_HI:   if (dp_ready)  fsm_d = last_rnd_c ? ST_DONE : ST_LO;
      ST_DONE: if (out_ready) fsm_d = ST_IDLE;
    endcase
  end

  // Handshake and datapath control decode
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    dp_valid  = 1'b0;
    dp_hi     = 1'b0;
    dp_mix    = 1'b0;
    dp_op_enc = 1'b0;
    dp_op_dec = 1'b0;
    case (fsm_q)
      ST_IDLE: in_ready = 1'b1;
      ST_LO: begin
        dp_valid  = 1'b1;
        dp_mix    = !last_rnd_c;
        dp_op_enc = !mode_q;
        dp_op_dec = mode_q;
      end
      ST_HI: begin
        dp_valid  = 1'b1;
        dp_hi     = 1'b1;
        dp_mix    = !last_rnd_c;
        dp_op_enc = !mode_q;
        dp_op_dec = mode_q;
      end
      ST_DONE: out_valid = 1'b1;
    endcase
  end

  // Block state, lo-half hold, mode and round counter
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q   <= '0;
      lo_hold_q <= '0;
      mode_q    <= 1'b0;
      rnd_q     <= '0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q <= ark_c;
            mode_q  <= in_dec;
            rnd_q   <= RND_FIRST;
          end
        end
        ST_LO: begin
          if (dp_ready) lo_hold_q <= dp_rd;
        end
        ST_HI: begin
          if (dp_ready) begin
            state_q <= ark_c;
            if (!last_rnd_c) rnd_q <= rnd_q + RKW'(1);
          end
        end
        ST_DONE: ;
      endcase
    end
  end

  assign out_blk = state_q;
  assign dp_rs1  = state_q[HALF_W-1:0];
  assign dp_rs2  = state_q[BLK_W-1:HALF_W];

endmodule

// File: tb/tb_aes64_block_ctrl.sv
// Bench for aes64_block_ctrl with a behavioural aes64 round datapath and key store.
module tb_aes64_block_ctrl;

  localparam int unsigned NR  = 10;
  localparam int unsigned RKW = 4;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic g_clk = 1'b0;
  logic g_resetn = 1'b0;
  logic in_valid, in_ready, in_dec, out_valid, out_ready;
  logic [127:0] in_blk, out_blk, rk;
  logic [RKW-1:0] rk_idx;
  logic dp_valid, dp_hi, dp_mix, dp_op_enc, dp_op_dec, dp_ready;
  logic [63:0] dp_rs1, dp_rs2, dp_rd;

  always #5 g_clk = ~g_clk;

  aes64_block_ctrl #(.NR(NR), .RKW(RKW)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_dec(in_dec), .in_blk(in_blk),
    .out_valid(out_valid), .out_ready(out_ready), .out_blk(out_blk),
    .rk_idx(rk_idx), .rk(rk),
    .dp_valid(dp_valid), .dp_hi(dp_hi), .dp_mix(dp_mix),
    .dp_op_enc(dp_op_enc), .dp_op_dec(dp_op_dec),
    .dp_rs1(dp_rs1), .dp_rs2(dp_rs2), .dp_rd(dp_rd), .dp_ready(dp_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- AES reference helpers ----------------
  logic [7:0] sbox [256];
  logic [7:0] isbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sb_calc(input logic [7:0] a);
    logic [7:0] p;
    p = 8'h01;
    if (a == 8'h00) p = 8'h00;
    else for (int i = 0; i < 254; i++) p = gm(p, a);
    return p ^ rl(p, 1) ^ rl(p, 2) ^ rl(p, 3) ^ rl(p, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] bswap(input logic [127:0] x);
    logic [127:0] y;
    for (int b = 0; b < 16; b++) y[8*b +: 8] = x[8*(15-b) +: 8];
    return y;
  endfunction

  function automatic logic [31:0] mix_word(input logic [31:0] col, input logic inv);
    logic [7:0] a [4];
    logic [31:0] o;
    for (int j = 0; j < 4; j++) a[j] = col[8*j +: 8];
    for (int j = 0; j < 4; j++) begin
      if (!inv)
        o[8*j +: 8] = gm(a[j], 8'd2) ^ gm(a[(j+1)%4], 8'd3) ^ a[(j+2)%4] ^ a[(j+3)%4];
      else
        o[8*j +: 8] = gm(a[j], 8'd14) ^ gm(a[(j+1)%4], 8'd11) ^
                      gm(a[(j+2)%4], 8'd13) ^ gm(a[(j+3)%4], 8'd9);
    end
    return o;
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic mix);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(r+4*c) +: 8] = sbox[s[8*(r+4*((c+r)%4)) +: 8]];
    if (mix) for (int c = 0; c < 4; c++) o[32*c +: 32] = mix_word(o[32*c +: 32], 1'b0);
    return o;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic mix);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(r+4*((c+r)%4)) +: 8] = isbox[s[8*(r+4*c) +: 8]];
    if (mix) for (int c = 0; c < 4; c++) o[32*c +: 32] = mix_word(o[32*c +: 32], 1'b1);
    return o;
  endfunction

  // ---------------- key store and datapath model ----------------
  logic [127:0] ek [16];
  logic [127:0] dk [16];
  logic cur_dec = 1'b0;

  assign rk = cur_dec ? dk[rk_idx] : ek[rk_idx];

  task automatic load_key(input logic [127:0] key_hex);
    logic [7:0] kb [16*(NR+1)];
    logic [7:0] t [4];
    logic [7:0] tmp, rc;
    for (int i = 0; i < 16; i++) kb[i] = key_hex[8*(15-i) +: 8];
    rc = 8'h01;
    for (int i = 16; i < 16*(NR+1); i += 4) begin
      for (int j = 0; j < 4; j++) t[j] = kb[i-4+j];
      if (i % 16 == 0) begin
        tmp  = t[0];
        t[0] = sbox[t[1]] ^ rc;
        t[1] = sbox[t[2]];
        t[2] = sbox[t[3]];
        t[3] = sbox[tmp];
        rc   = xt(rc);
      end
      for (int j = 0; j < 4; j++) kb[i+j] = kb[i-16+j] ^ t[j];
    end
    for (int r = 0; r < 16; r++) begin
      ek[r] = '0;
      dk[r] = '0;
    end
    for (int r = 0; r <= NR; r++) begin
      for (int b = 0; b < 16; b++) ek[r][8*b +: 8] = kb[16*r + b];
      dk[r] = ek[r];
      if (r != 0 && r != NR)
        for (int c = 0; c < 4; c++) dk[r][32*c +: 32] = mix_word(ek[r][32*c +: 32], 1'b1);
    end
  endtask

  logic [127:0] dp_full;
  always_comb begin
    dp_full = '0;
    if (dp_op_dec) dp_full = dec_round({dp_rs2, dp_rs1}, dp_mix);
    else           dp_full = enc_round({dp_rs2, dp_rs1}, dp_mix);
    dp_rd = dp_hi ? dp_full[127:64] : dp_full[63:0];
  end

  // Datapath ready with optional 0-3 cycle stalls per op
  bit stall_en = 1'b0;
  int stall_cnt = 0;
  assign dp_ready = (stall_cnt == 0);
  always @(posedge g_clk) begin
    if (!dp_valid) stall_cnt <= 0;
    else if (stall_cnt == 0) stall_cnt <= stall_en ? int'($urandom_range(0, 3)) : 0;
    else stall_cnt <= stall_cnt - 1;
  end

  // ---------------- monitors ----------------
  int op_cnt;
  always @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) op_cnt <= 0;
    else if (in_valid && in_ready) op_cnt <= 0;
    else if (dp_valid && dp_ready) op_cnt <= op_cnt + 1;
  end

  int rk_log [$];
  always @(posedge g_clk) begin
    if (g_resetn && in_valid && in_ready) rk_log.push_back(int'(rk_idx));
    if (g_resetn && dp_valid && dp_hi && dp_ready) rk_log.push_back(int'(rk_idx));
  end

  logic [136:0] dp_snap, prev_snap;
  logic prev_stall;
  assign dp_snap = {dp_valid, dp_hi, dp_mix, dp_op_enc, dp_op_dec, dp_rs2, dp_rs1, rk_idx};

  // Stall stability, op one-hot and mix pattern
  always @(negedge g_clk) begin
    if (!g_resetn) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) check("dp_hold_stable", dp_snap, prev_snap);
      if (dp_valid) begin
        check("dp_op_onehot", {dp_op_enc, dp_op_dec}, cur_dec ? 2'b01 : 2'b10);
        check("dp_mix", dp_mix, (op_cnt < 2*(NR-1)) ? 1'b1 : 1'b0);
      end else begin
        check("dp_op_idle", {dp_op_enc, dp_op_dec}, 2'b00);
      end
      prev_stall <= dp_valid && !dp_ready;
      prev_snap  <= dp_snap;
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, {in_ready, out_valid, dp_valid, dp_hi, dp_mix, dp_op_enc, dp_op_dec},
          7'b1000000);
    check({tag, "_rk_idx"}, rk_idx, 0);
    check({tag, "_out_blk"}, out_blk, 0);
    check({tag, "_dp_rs"}, {dp_rs2, dp_rs1}, 0);
  endtask

  task automatic start_block(input logic dec, input logic [127:0] blk);
    int n;
    @(negedge g_clk);
    rk_log.delete();
    cur_dec  = dec;
    in_dec   = dec;
    in_blk   = blk;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge g_clk);
      n++;
    end
    check("in_ready_wait", in_ready, 1'b1);
    @(posedge g_clk);
    @(negedge g_clk);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 2000) begin
      @(negedge g_clk);
      lat++;
    end
    check("out_valid_wait", out_valid, 1'b1);
  endtask

  task automatic run_block(input logic dec, input logic [127:0] blk,
                           output logic [127:0] got, output int lat);
    start_block(dec, blk);
    in_valid = 1'b0;
    wait_out(lat);
    got = out_blk;
    out_ready = 1'b1;
    @(negedge g_clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic         dec;
    logic [127:0] key;
    logic [127:0] blk;
    logic [127:0] exp;
    logic         stall;
  } vec_t;

  initial begin
    vec_t vecs [8];
    logic [127:0] got;
    int lat, n;

    in_valid = 1'b0; in_dec = 1'b0; in_blk = '0; out_ready = 1'b0;
    for (int a = 0; a < 256; a++) sbox[a] = sb_calc(8'(a));
    for (int a = 0; a < 256; a++) isbox[sbox[a]] = 8'(a);
    load_key(K1);

    vecs[0] = '{dec: 1'b0, key: K1, blk: P1, exp: C1, stall: 1'b0};
    vecs[1] = '{dec: 1'b1, key: K1, blk: C1, exp: P1, stall: 1'b0};
    vecs[2] = '{dec: 1'b0, key: K2, blk: P2, exp: C2, stall: 1'b0};
    vecs[3] = '{dec: 1'b1, key: K2, blk: C2, exp: P2, stall: 1'b0};
    vecs[4] = '{dec: 1'b0, key: K1, blk: P1, exp: C1, stall: 1'b1};
    vecs[5] = '{dec: 1'b1, key: K1, blk: C1, exp: P1, stall: 1'b1};
    vecs[6] = '{dec: 1'b0, key: K2, blk: P2, exp: C2, stall: 1'b1};
    vecs[7] = '{dec: 1'b1, key: K2, blk: C2, exp: P2, stall: 1'b1};

    repeat (3) @(negedge g_clk);
    check_reset("reset");
    g_resetn = 1'b1;

    for (int v = 0; v < 8; v++) begin
      stall_en = vecs[v].stall;
      load_key(vecs[v].key);
      run_block(vecs[v].dec, bswap(vecs[v].blk), got, lat);
      check($sformatf("vec%0d_blk", v), got, bswap(vecs[v].exp));
      if (!vecs[v].stall) check($sformatf("vec%0d_latency", v), lat, 2*NR);
      check($sformatf("vec%0d_rk_len", v), rk_log.size(), NR+1);
      for (int i = 0; i < rk_log.size() && i <= int'(NR); i++)
        check($sformatf("vec%0d_rk_idx%0d", v, i), rk_log[i], vecs[v].dec ? int'(NR)-i : i);
    end
    stall_en = 1'b0;

    // Backpressure in DONE with a new request already waiting
    load_key(K1);
    start_block(1'b0, bswap(P1));
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_blk", out_blk, bswap(C1));
      check("bp_flags", {out_valid, in_ready}, 2'b10);
      @(negedge g_clk);
    end
    out_ready = 1'b1;
    @(negedge g_clk);
    out_ready = 1'b0;
    check("bp_no_accept_on_handshake", {in_ready, out_valid, dp_valid}, 3'b100);
    @(negedge g_clk);
    in_valid = 1'b0;
    check("bp_accept_next", {in_ready, dp_valid}, 2'b01);
    wait_out(lat);
    check("bp_second_blk", out_blk, bswap(C1));
    out_ready = 1'b1;
    @(negedge g_clk);
    out_ready = 1'b0;

    // Reset during round 4 HI, then a clean encrypt
    start_block(1'b0, bswap(P1));
    in_valid = 1'b0;
    n = 0;
    while (!(dp_valid && dp_hi && op_cnt == 7) && n < 200) begin
      @(negedge g_clk);
      n++;
    end
    check("rst_reach_r4_hi", (n < 200) ? 1'b1 : 1'b0, 1'b1);
    g_resetn = 1'b0;
    in_dec   = 1'b0;
    cur_dec  = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge g_clk);
    check_reset("midrst_hold");
    g_resetn = 1'b1;
    run_block(1'b0, bswap(P1), got, lat);
    check("post_rst_blk", got, bswap(C1));
    check("post_rst_latency", lat, 2*NR);

    repeat (2) @(negedge g_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
